// File: rtl/pool1.sv
// pool1: 2x2 stride-2 signed max pooling over POOL1_DEEP feature maps.
// Reads four samples per window from the conv-result BRAM, tracks the
// running maximum, and writes one result per window to the pool BRAM.
// Optional feature macro: POOL1_RELU_EN clamps negative results to zero.
module pool1 #(
    parameter int DATA_SIZE    = 16,
    parameter int POOL1_INPUT  = 24,
    parameter int POOL1_OUTPUT = 12,
    parameter int POOL1_DEEP   = 6,
    parameter int RD_LAT       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pool_1_en,
    output logic                        conv_result_bram_ena,
    output logic [11:0]                 conv_result_bram_addra,
    input  logic signed [DATA_SIZE-1:0] conv_result_bram_douta,
    output logic                        pool_bram_wea,
    output logic [9:0]                  pool_bram_addra,
    output logic signed [DATA_SIZE-1:0] pool_bram_dina,
    output logic                        pool_1_finish
);

    localparam int CH_W = (POOL1_DEEP > 1) ? $clog2(POOL1_DEEP) : 1;
    localparam int RC_W = (POOL1_OUTPUT > 1) ? $clog2(POOL1_OUTPUT) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(POOL1_DEEP - 1);
    localparam logic [RC_W-1:0] LAST_RC = RC_W'(POOL1_OUTPUT - 1);
    localparam logic [1:0]      LAST_WT = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [RC_W-1:0]             r_q, r_d;
    logic [RC_W-1:0]             c_q, c_d;
    logic [1:0]                  k_q, k_d;      // sample index within a window
    logic [1:0]                  wt_q, wt_d;    // cycles spent in S_WAIT
    logic [2:0]                  vld_q, vld_d;  // read-issued delay line
    logic [2:0]                  first_q, first_d; // marks sample 0 in the delay line
    logic signed [DATA_SIZE-1:0] max_q, max_d;

    logic [11:0] rd_addr;
    logic [9:0]  wr_addr;
    logic signed [DATA_SIZE-1:0] result;

    // State, counters, read-return tracking and running max.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            wt_q    <= '0;
            vld_q   <= '0;
            first_q <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            wt_q    <= wt_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            max_q   <= max_d;
        end
    end

    // Next-state, counter advance and max capture from the returning read data.
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        wt_d    = wt_q;
        max_d   = max_q;
        vld_d   = {vld_q[1:0], (state_q == S_READ)};
        first_d = {first_q[1:0], (state_q == S_READ) && (k_q == 2'd0)};

        // Data issued RD_LAT cycles ago is on douta now.
        if (vld_q[RD_LAT-1]) begin
            if (first_q[RD_LAT-1] || (conv_result_bram_douta > max_q)) begin
                max_d = conv_result_bram_douta;
            end
        end

        if (!pool_1_en) begin
            state_d = S_IDLE;
            vld_d   = '0;
            first_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ch_d    = '0;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    state_d = S_READ;
                end
                S_READ: begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        wt_d    = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    wt_d = wt_q + 2'd1;
                    if (wt_q == LAST_WT) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    k_d     = '0;
                    state_d = S_READ;
                    if (c_q == LAST_RC) begin
                        c_d = '0;
                        if (r_q == LAST_RC) begin
                            r_d = '0;
                            if (ch_q == LAST_CH) begin
                                state_d = S_DONE;
                            end else begin
                                ch_d = ch_q + 1'b1;
                            end
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Address generation and output decode; addresses and data are zero when not strobed.
    always_comb begin
        rd_addr = 12'(ch_q) * 12'(POOL1_INPUT * POOL1_INPUT)
                + (12'({r_q, 1'b0}) + 12'(k_q[1])) * 12'(POOL1_INPUT)
                + 12'({c_q, 1'b0}) + 12'(k_q[0]);
        wr_addr = 10'(ch_q) * 10'(POOL1_OUTPUT * POOL1_OUTPUT)
                + 10'(r_q) * 10'(POOL1_OUTPUT) + 10'(c_q);
`ifdef POOL1_RELU_EN
        result = max_q[DATA_SIZE-1] ? '0 : max_q;
`else
        result = max_q;
`endif
        conv_result_bram_ena   = (state_q == S_READ);
        conv_result_bram_addra = conv_result_bram_ena ? rd_addr : '0;
        pool_bram_wea          = (state_q == S_WRITE);
        pool_bram_addra        = pool_bram_wea ? wr_addr : '0;
        pool_bram_dina         = pool_bram_wea ? result : '0;
        pool_1_finish          = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_pool1.sv
// tb_pool1: directed run sequence for pool1 with random and ramp data,
// a behavioural BRAM model, and a window-max reference computed from the input map.
module tb_pool1;

    localparam int DS     = 16;
    localparam int PI     = 24;
    localparam int PO     = 12;
    localparam int PD     = 6;
    localparam int RL     = 2;
    localparam int NIN    = PI * PI * PD;
    localparam int NOUT   = PO * PO * PD;
    localparam int PERIOD = 5 + RL;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic ena;
    logic [11:0] raddr;
    logic signed [DS-1:0] douta;
    logic wea;
    logic [9:0] waddr;
    logic signed [DS-1:0] dina;
    logic fin;

    always #5 clk = ~clk;

    pool1 #(
        .DATA_SIZE(DS), .POOL1_INPUT(PI), .POOL1_OUTPUT(PO), .POOL1_DEEP(PD), .RD_LAT(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pool_1_en(en),
        .conv_result_bram_ena(ena),
        .conv_result_bram_addra(raddr),
        .conv_result_bram_douta(douta),
        .pool_bram_wea(wea),
        .pool_bram_addra(waddr),
        .pool_bram_dina(dina),
        .pool_1_finish(fin)
    );

    // Conv-result BRAM model: data for an address appears RL edges after it is presented.
    logic signed [DS-1:0] in_mem [0:NIN-1];
    logic [11:0] pipe_addr [0:2];
    always @(posedge clk) begin
        pipe_addr[0] <= raddr;
        pipe_addr[1] <= pipe_addr[0];
        pipe_addr[2] <= pipe_addr[1];
    end
    assign douta = (int'(pipe_addr[RL-1]) < NIN) ? in_mem[pipe_addr[RL-1]] : '0;

    // Transaction logger for reads, writes and strobe-exclusivity violations.
    logic clr = 1'b0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int viol = 0;
    int rd_log [0:NIN-1];
    int wr_log [0:NOUT-1];
    logic signed [DS-1:0] out_mem [0:NOUT-1];
    bit written [0:NOUT-1];
    always @(posedge clk) begin
        if (clr) begin
            rd_cnt <= 0;
            wr_cnt <= 0;
            for (int i = 0; i < NOUT; i++) written[i] <= 1'b0;
        end else begin
            if (ena) begin
                if (rd_cnt < NIN) rd_log[rd_cnt] <= int'(raddr);
                rd_cnt <= rd_cnt + 1;
            end
            if (wea) begin
                if (wr_cnt < NOUT) wr_log[wr_cnt] <= int'(waddr);
                wr_cnt <= wr_cnt + 1;
                if (int'(waddr) < NOUT) begin
                    out_mem[waddr] <= dina;
                    written[waddr] <= 1'b1;
                end
            end
        end
        if ((ena && wea) || (fin && (ena || wea))) viol <= viol + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: max of the 2x2 window feeding output index o.
    function automatic logic signed [DS-1:0] ref_out(input int o);
        int ch, r, c, base;
        logic signed [DS-1:0] m;
        ch   = o / (PO * PO);
        r    = (o % (PO * PO)) / PO;
        c    = o % PO;
        base = ch * PI * PI + 2 * r * PI + 2 * c;
        m = in_mem[base];
        if (in_mem[base + 1] > m)      m = in_mem[base + 1];
        if (in_mem[base + PI] > m)     m = in_mem[base + PI];
        if (in_mem[base + PI + 1] > m) m = in_mem[base + PI + 1];
`ifdef POOL1_RELU_EN
        if (m < 0) m = '0;
`endif
        return m;
    endfunction

    // Expected read address j (0..3) of window w.
    function automatic int ref_rd(input int w, input int j);
        int ch, r, c;
        ch = w / (PO * PO);
        r  = (w % (PO * PO)) / PO;
        c  = w % PO;
        return ch * PI * PI + (2 * r + j / 2) * PI + 2 * c + (j % 2);
    endfunction

    task automatic clear_logs();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_full(input string tag);
        int cyc;
        int bad_rd;
        clear_logs();
        en  = 1'b1;
        cyc = 0;
        while (!fin && cyc < 2 * NOUT * PERIOD) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_run_cycles"}, cyc, NOUT * PERIOD + 1);
        check({tag, "_write_count"}, wr_cnt, NOUT);
        check({tag, "_read_count"}, rd_cnt, 4 * NOUT);
        bad_rd = 0;
        for (int w = 0; w < NOUT; w++)
            for (int j = 0; j < 4; j++)
                if (rd_log[4 * w + j] != ref_rd(w, j)) bad_rd++;
        check({tag, "_read_order_errors"}, bad_rd, 0);
        for (int o = 0; o < NOUT; o++) begin
            check($sformatf("%s_out%0d", tag, o), out_mem[o], ref_out(o));
        end
    endtask

    int base;
    logic signed [DS-1:0] neg_exp;

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < NIN; i++) in_mem[i] = DS'($urandom);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_strobes", {ena, wea, fin}, 0);
        check("rst_addr", {raddr, waddr}, 0);
        check("rst_dina", dina, 0);
        rst = 1'b1;

        // Random data with directed windows 0..2 (negatives, ties, max first).
        in_mem[0] = -16'sd5;  in_mem[1] = -16'sd3;  in_mem[PI] = -16'sd9;  in_mem[PI+1] = -16'sd4;
        in_mem[2] = 16'sd7;   in_mem[3] = 16'sd7;   in_mem[PI+2] = 16'sd2; in_mem[PI+3] = 16'sd7;
        in_mem[4] = 16'sh7FFF; in_mem[5] = 16'sd0;  in_mem[PI+4] = 16'sd0; in_mem[PI+5] = 16'sd0;
        run_full("rand");
`ifdef POOL1_RELU_EN
        neg_exp = 16'sd0;
`else
        neg_exp = -16'sd3;
`endif
        check("neg_window", out_mem[0], neg_exp);
        check("tie_window", out_mem[1], 7);
        check("maxfirst_window", out_mem[2], 32'sh7FFF);
        check("last_rd0", rd_log[4 * 863 + 0], 3430);
        check("last_rd1", rd_log[4 * 863 + 1], 3431);
        check("last_rd2", rd_log[4 * 863 + 2], 3454);
        check("last_rd3", rd_log[4 * 863 + 3], 3455);
        check("last_wr", wr_log[863], 863);
        check("ch1_rd0", rd_log[4 * 144 + 0], 576);
        check("ch1_rd1", rd_log[4 * 144 + 1], 577);
        check("ch1_rd2", rd_log[4 * 144 + 2], 600);
        check("ch1_rd3", rd_log[4 * 144 + 3], 601);
        check("ch1_wr", wr_log[144], 144);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("done_hold", {fin, ena, wea}, 3'b100);
        end
        en = 1'b0;
        @(negedge clk);
        check("done_release", {fin, ena, wea}, 0);

        // Ramp data.
        for (int i = 0; i < NIN; i++) in_mem[i] = DS'(i % 32768);
        run_full("ramp");
        check("ramp_out0", out_mem[0], 25);
        check("ramp_out144", out_mem[144], 601);
        check("ramp_out863", out_mem[863], 3455);
        en = 1'b0;

        // Abort during S_WAIT of window 50, then restart.
        clear_logs();
        en = 1'b1;
        for (int i = 0; i < 100 * PERIOD && wr_cnt < 50; i++) @(negedge clk);
        check("abort_reach50", wr_cnt, 50);
        for (int i = 0; i < 10 && !ena; i++) @(negedge clk);
        for (int i = 0; i < 10 && ena; i++) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_outputs", {ena, wea, fin}, 0);
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("abort_no_wr50", written[50], 0);
        check("abort_wr_count", wr_cnt, 50);
        clear_logs();
        en = 1'b1;
        for (int i = 0; i < 4 * PERIOD && wr_cnt < 1; i++) @(negedge clk);
        check("restart_first_wr", wr_log[0], 0);
        check("restart_first_val", out_mem[0], ref_out(0));
        en = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-S_READ.
        clear_logs();
        en = 1'b1;
        for (int i = 0; i < 10 * PERIOD && wr_cnt < 3; i++) @(negedge clk);
        for (int i = 0; i < 10 && !ena; i++) @(negedge clk);
        check("rst_mid_in_read", ena, 1);
        #2;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        check("rst_async_strobes", {ena, wea, fin}, 0);
        check("rst_async_addr", {raddr, waddr}, 0);
        check("rst_async_dina", dina, 0);
        base = wr_cnt;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("rst_no_write", wr_cnt, base);
        en = 1'b1;
        for (int i = 0; i < 4 * PERIOD && wr_cnt <= base; i++) @(negedge clk);
        check("rst_restart_wr", wr_log[base], 0);
        en = 1'b0;
        @(negedge clk);

        check("protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
